// File: rtl/key_search_pkg.sv
// Shared defaults and state encoding for the RC4 key search sequencer.
package key_search_pkg;

  localparam int unsigned KS_KEY_WIDTH      = 24;
  localparam logic [23:0] KS_KEY_FIRST      = 24'h000000;
  localparam logic [23:0] KS_KEY_LAST       = 24'h3FFFFF;
  localparam int unsigned KS_TIMEOUT_CYCLES = 65535;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_DEC_GO    = 4'd2,
    S_DEC_WAIT  = 4'd3,
    S_CHK_GO    = 4'd4,
    S_CHK_WAIT  = 4'd5,
    S_NEXT      = 4'd6,
    S_FOUND     = 4'd7,
    S_EXHAUSTED = 4'd8
  } ks_state_e;

  // A search is in progress in every state except the three resting ones.
  function automatic logic state_is_busy(input logic [3:0] st);
    logic busy_v;
    case (st)
      S_IDLE, S_FOUND, S_EXHAUSTED: busy_v = 1'b0;
      default:                      busy_v = 1'b1;
    endcase
    return busy_v;
  endfunction

endpackage

// File: rtl/key_search_watchdog.sv
// Wait-state cycle counter for the key search sequencer; flags when a single
// decrypt or check wait has lasted LIMIT cycles.
module key_search_watchdog #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic active,
  output logic expired
);

  localparam int unsigned CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(LIMIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_r;

  // Cleared just before each wait state, saturates at the last waiting cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (active && (cnt_r != LIMIT_M1)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = active && (cnt_r == LIMIT_M1);

endmodule

// File: rtl/key_search_ctrl.sv
// Top-level sequencer stepping RC4 candidate keys through decrypt and ASCII check.
// Optional per-wait watchdog enabled by defining KEY_SEARCH_TIMEOUT_EN.
module key_search_ctrl
  import key_search_pkg::*;
#(
  parameter int unsigned          KEY_WIDTH      = KS_KEY_WIDTH,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST      = KEY_WIDTH'(KS_KEY_FIRST),
  parameter logic [KEY_WIDTH-1:0] KEY_LAST       = KEY_WIDTH'(KS_KEY_LAST),
  parameter int unsigned          TIMEOUT_CYCLES = KS_TIMEOUT_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 decrypt_start,
  input  logic                 decrypt_finish,
  output logic                 check_start,
  input  logic                 check_finish,
  input  logic                 check_valid,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic                 timeout_err
);

  localparam logic [3:0] ST_IDLE      = S_IDLE;
  localparam logic [3:0] ST_LOAD      = S_LOAD;
  localparam logic [3:0] ST_DEC_GO    = S_DEC_GO;
  localparam logic [3:0] ST_DEC_WAIT  = S_DEC_WAIT;
  localparam logic [3:0] ST_CHK_GO    = S_CHK_GO;
  localparam logic [3:0] ST_CHK_WAIT  = S_CHK_WAIT;
  localparam logic [3:0] ST_NEXT      = S_NEXT;
  localparam logic [3:0] ST_FOUND     = S_FOUND;
  localparam logic [3:0] ST_EXHAUSTED = S_EXHAUSTED;

  localparam logic [KEY_WIDTH-1:0] KEY_ONE = {{(KEY_WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]           state_r;
  logic [3:0]           state_nxt_s;
  logic [KEY_WIDTH-1:0] key_r;
  logic [KEY_WIDTH-1:0] key_nxt_s;
  logic                 timeout_nxt_s;
  logic                 at_last_s;
  logic                 wdg_expired_s;
  logic                 decrypt_start_r;
  logic                 check_start_r;
  logic                 busy_r;
  logic                 found_r;
  logic                 exhausted_r;
  logic                 timeout_err_r;

  assign at_last_s = (key_r == KEY_LAST);

`ifdef KEY_SEARCH_TIMEOUT_EN
  logic wdg_clear_s;
  logic wdg_active_s;

  assign wdg_clear_s  = (state_r == ST_DEC_GO)   || (state_r == ST_CHK_GO);
  assign wdg_active_s = (state_r == ST_DEC_WAIT) || (state_r == ST_CHK_WAIT);

  key_search_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (wdg_clear_s),
    .active  (wdg_active_s),
    .expired (wdg_expired_s)
  );
`else
  assign wdg_expired_s = 1'b0;
`endif

  // Next-state, key and timeout-flag decode; abort overrides everything.
  always_comb begin
    state_nxt_s   = state_r;
    key_nxt_s     = key_r;
    timeout_nxt_s = timeout_err_r;
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
          if (start) begin
            state_nxt_s   = ST_LOAD;
            key_nxt_s     = KEY_FIRST;
            timeout_nxt_s = 1'b0;
          end else begin
            state_nxt_s = state_r;
          end
        end
        ST_LOAD:   state_nxt_s = ST_DEC_GO;
        ST_DEC_GO: state_nxt_s = ST_DEC_WAIT;
        ST_DEC_WAIT: begin
          if (decrypt_finish) begin
            state_nxt_s = ST_CHK_GO;
          end else if (wdg_expired_s) begin
            state_nxt_s   = ST_EXHAUSTED;
            timeout_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_DEC_WAIT;
          end
        end
        ST_CHK_GO: state_nxt_s = ST_CHK_WAIT;
        ST_CHK_WAIT: begin
          if (check_finish && check_valid) begin
            state_nxt_s = ST_FOUND;
          end else if (check_finish && at_last_s) begin
            state_nxt_s = ST_EXHAUSTED;
          end else if (check_finish) begin
            state_nxt_s = ST_NEXT;
          end else if (wdg_expired_s) begin
            state_nxt_s   = ST_EXHAUSTED;
            timeout_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_CHK_WAIT;
          end
        end
        ST_NEXT: begin
          state_nxt_s = ST_DEC_GO;
          // Never wrap, even when KEY_LAST is the all-ones key.
          if (!at_last_s) begin
            key_nxt_s = key_r + KEY_ONE;
          end else begin
            key_nxt_s = key_r;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, key and outputs, all registered from the decoded next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r         <= ST_IDLE;
      key_r           <= KEY_FIRST;
      decrypt_start_r <= 1'b0;
      check_start_r   <= 1'b0;
      busy_r          <= 1'b0;
      found_r         <= 1'b0;
      exhausted_r     <= 1'b0;
      timeout_err_r   <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      key_r           <= key_nxt_s;
      decrypt_start_r <= (state_nxt_s == ST_DEC_GO);
      check_start_r   <= (state_nxt_s == ST_CHK_GO);
      busy_r          <= state_is_busy(state_nxt_s);
      found_r         <= (state_nxt_s == ST_FOUND);
      exhausted_r     <= (state_nxt_s == ST_EXHAUSTED);
      timeout_err_r   <= timeout_nxt_s;
    end
  end

  assign key           = key_r;
  assign decrypt_start = decrypt_start_r;
  assign check_start   = check_start_r;
  assign busy          = busy_r;
  assign found         = found_r;
  assign exhausted     = exhausted_r;
  assign timeout_err   = timeout_err_r;

endmodule
